ft_tx_writer: RTL and testbench

//  FPGA->host transmit path for the FT245-style synchronous FIFO interface (ft_clk domain).

---
 rtl/ft_pkg.sv | 14 +
 rtl/ft_tx_writer_if.sv | 15 +
 rtl/ft_tx_fifo.sv | 54 +++++
 rtl/ft_tx_writer.sv | 194 +++++++++++++++++++
 tb/tb_ft_tx_writer.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ft_pkg.sv
// Shared types and widths for the FT245-style synchronous FIFO transmit path.
package ft_pkg;

  localparam int FT_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    TURN    = 3'd2,
    WRITE   = 3'd3,
    RELEASE = 3'd4
  } ft_tx_state_t;

endpackage

// File: rtl/ft_tx_writer_if.sv
// Byte stream from internal logic (status, calib readback) into the FT transmit writer.
interface ft_tx_writer_if;
  import ft_pkg::*;

  // Handshake: a byte transfers on an ft_clk edge where tx_valid && tx_ready.
  // The source holds tx_data stable while tx_valid is high and not yet taken;
  // tx_ready does not depend on tx_valid.
  logic [FT_BYTE_W-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/ft_tx_fifo.sv
// First-word-fall-through byte buffer; also exposes the entry behind the head so
// the writer can load the next byte into its output register on the same edge it pops.
module ft_tx_fifo
  import ft_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [FT_BYTE_W-1:0]     din_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [FT_BYTE_W-1:0]     head_o,
  output logic [FT_BYTE_W-1:0]     next_o
);

  localparam int AW = $clog2(DEPTH);

  logic [FT_BYTE_W-1:0] mem_q [DEPTH];
  logic [AW:0]          wr_q;
  logic [AW:0]          rd_q;
  logic [AW-1:0]        rd_nxt;
  logic                 do_push;
  logic                 do_pop;

  // A full buffer refuses pushes even when a pop happens on the same edge.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  assign rd_nxt  = rd_q[AW-1:0] + 1'b1;
  assign count_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign next_o  = mem_q[rd_nxt];

endmodule

// File: rtl/ft_tx_writer.sv
// FPGA->host transmit writer for the FT245 synchronous FIFO bus: arbitrates for ft_data,
// bursts buffered bytes with WR#, re-presents refused bytes and issues SIWU# after idle.
module ft_tx_writer
  import ft_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int MAX_BURST = 64,
  parameter int SIWU_IDLE = 32
) (
  input  logic                 ft_clk,
  input  logic                 rst_n,
  ft_tx_writer_if.slave        tx_if,
  input  logic                 ft_txen,
  output logic                 ft_wrn,
  output logic                 ft_siwu,
  output logic [FT_BYTE_W-1:0] ft_data_out,
  output logic                 ft_data_oe,
  output logic                 bus_req,
  input  logic                 bus_gnt,
  input  logic                 bus_yield,
  output logic [15:0]          tx_count,
  output ft_tx_state_t         dbg_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(SIWU_IDLE + 1);

  ft_tx_state_t         state_q, state_d;
  logic                 wrn_q, wrn_d;
  logic                 oe_q, oe_d;
  logic                 req_q, req_d;
  logic                 siwu_q, siwu_d;
  logic [FT_BYTE_W-1:0] data_q, data_d;
  logic [BW-1:0]        burst_q, burst_d;
  logic [IW-1:0]        idle_q, idle_d;
  logic                 armed_q, armed_d;
  logic [15:0]          cnt_q;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [AW:0]          fifo_cnt;
  logic [FT_BYTE_W-1:0] fifo_head;
  logic [FT_BYTE_W-1:0] fifo_next;
  logic                 accept;
  logic                 last_byte;
  logic                 burst_done;

  ft_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (ft_clk),
    .rst_n   (rst_n),
    .push_i  (tx_if.tx_valid),
    .din_i   (tx_if.tx_data),
    .pop_i   (accept),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt),
    .head_o  (fifo_head),
    .next_o  (fifo_next)
  );

  assign tx_if.tx_ready = !fifo_full;

  // WR# is only ever low in WRITE, so this is exactly "chip took the byte on ft_data".
  assign accept     = (state_q == WRITE) && !wrn_q && !ft_txen;
  assign last_byte  = accept && (fifo_cnt == {{AW{1'b0}}, 1'b1});
  assign burst_done = accept && (burst_q == BW'(MAX_BURST - 1));

  always_comb begin
    state_d = state_q;
    wrn_d   = wrn_q;
    oe_d    = oe_q;
    req_d   = req_q;
    data_d  = data_q;
    burst_d = burst_q;
    if (accept) begin
      if (burst_q != BW'(MAX_BURST)) burst_d = burst_q + 1'b1;
      if (!last_byte) data_d = fifo_next;
    end
    case (state_q)
      IDLE: begin
        wrn_d = 1'b1;
        oe_d  = 1'b0;
        if (!fifo_empty && !ft_txen) begin
          state_d = REQ;
          req_d   = 1'b1;
        end
      end
      REQ: begin
        if (bus_gnt) begin
          state_d = TURN;
          oe_d    = 1'b1;
          data_d  = fifo_head;
          burst_d = '0;
        end
      end
      TURN: begin
        if (!bus_gnt) begin
          state_d = REQ;
          oe_d    = 1'b0;
        end else if (ft_txen) begin
          state_d = RELEASE;
        end else begin
          state_d = WRITE;
          wrn_d   = 1'b0;
        end
      end
      WRITE: begin
        // Losing the grant abandons the bus at once; unaccepted bytes stay buffered.
        if (!bus_gnt) begin
          wrn_d = 1'b1;
          oe_d  = 1'b0;
          if (last_byte) begin
            state_d = IDLE;
            req_d   = 1'b0;
          end else begin
            state_d = REQ;
          end
        end else if (bus_yield || ft_txen || last_byte || burst_done) begin
          state_d = RELEASE;
          wrn_d   = 1'b1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        wrn_d   = 1'b1;
        oe_d    = 1'b0;
        req_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        wrn_d   = 1'b1;
        oe_d    = 1'b0;
        req_d   = 1'b0;
      end
    endcase
  end

  // Send-immediate: one pulse per quiet spell following at least one accepted byte.
  always_comb begin
    idle_d  = idle_q;
    armed_d = armed_q;
    siwu_d  = 1'b1;
    if (accept) begin
      idle_d  = '0;
      armed_d = 1'b1;
    end else if (state_q == IDLE && fifo_empty && armed_q && !oe_q) begin
      if (idle_q == IW'(SIWU_IDLE - 1)) begin
        siwu_d  = 1'b0;
        armed_d = 1'b0;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else begin
      idle_d = '0;
    end
  end

  always_ff @(posedge ft_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wrn_q   <= 1'b1;
      oe_q    <= 1'b0;
      req_q   <= 1'b0;
      siwu_q  <= 1'b1;
      data_q  <= '0;
      burst_q <= '0;
      idle_q  <= '0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wrn_q   <= wrn_d;
      oe_q    <= oe_d;
      req_q   <= req_d;
      siwu_q  <= siwu_d;
      data_q  <= data_d;
      burst_q <= burst_d;
      idle_q  <= idle_d;
      armed_q <= armed_d;
      if (accept) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ft_wrn      = wrn_q;
  assign ft_siwu     = siwu_q;
  assign ft_data_out = data_q;
  assign ft_data_oe  = oe_q;
  assign bus_req     = req_q;
  assign tx_count    = cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ft_tx_writer.sv
// Directed bench for ft_tx_writer: an FT chip model logs every accepted byte against
// the bytes pushed, and each scenario task checks its cycle-exact bus behaviour inline.
`timescale 1ns/1ps
module tb_ft_tx_writer;
  import ft_pkg::*;

  logic         ft_clk = 1'b0;
  logic         rst_n  = 1'b0;
  logic         ft_txen = 1'b1;
  logic         bus_gnt = 1'b0;
  logic         bus_yield = 1'b0;
  logic         ft_wrn;
  logic         ft_siwu;
  logic [7:0]   ft_data_out;
  logic         ft_data_oe;
  logic         bus_req;
  logic [15:0]  tx_count;
  ft_tx_state_t dbg_state;

  ft_tx_writer_if tx_if ();

  ft_tx_writer #(.DEPTH(16), .MAX_BURST(64), .SIWU_IDLE(32)) dut (
    .ft_clk      (ft_clk),
    .rst_n       (rst_n),
    .tx_if       (tx_if),
    .ft_txen     (ft_txen),
    .ft_wrn      (ft_wrn),
    .ft_siwu     (ft_siwu),
    .ft_data_out (ft_data_out),
    .ft_data_oe  (ft_data_oe),
    .bus_req     (bus_req),
    .bus_gnt     (bus_gnt),
    .bus_yield   (bus_yield),
    .tx_count    (tx_count),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #8 ft_clk = ~ft_clk;

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_q[$];
  logic [7:0]  sb_exp;
  logic [15:0] exp_cnt = '0;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_acc_cyc = 0;
  int          ten_acc = 0;
  int          ten_q[$];
  logic        req_prev = 1'b0;

  // FT chip model: a byte is taken on any edge with WR# and TXE# both low.
  always @(posedge ft_clk) begin
    if (rst_n && !ft_wrn && !ft_txen) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL host_rx unexpected byte got=%02h want=none", ft_data_out);
      end else begin
        sb_exp = exp_q.pop_front();
        if (ft_data_out !== sb_exp) begin
          n_err++;
          $display("FAIL host_rx byte got=%02h want=%02h", ft_data_out, sb_exp);
        end
      end
      last_acc_cyc = cyc;
      ten_acc++;
    end
    cyc++;
  end

  always @(negedge ft_clk) begin
    if (req_prev && !bus_req) begin
      ten_q.push_back(ten_acc);
      ten_acc = 0;
    end
    req_prev = bus_req;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge ft_clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, output bit ok);
    int g = 0;
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    @(negedge ft_clk);
    while (!tx_if.tx_ready && g < 2000) begin
      @(negedge ft_clk);
      g++;
    end
    ok = (g < 2000);
    @(posedge ft_clk);
    #1;
    tx_if.tx_valid = 1'b0;
    if (ok) begin
      exp_q.push_back(b);
      exp_cnt = exp_cnt + 16'd1;
    end
  endtask

  task automatic wait_drained(output bit ok);
    int g = 0;
    while ((exp_q.size() != 0 || dbg_state != IDLE) && g < 3000) begin
      @(negedge ft_clk);
      g++;
    end
    ok = (g < 3000);
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    repeat (3) @(negedge ft_clk);
    n_vec++; if (ft_wrn !== 1'b1)      begin n_err++; $display("FAIL reset_wrn got=%b want=1", ft_wrn); end
    n_vec++; if (ft_siwu !== 1'b1)     begin n_err++; $display("FAIL reset_siwu got=%b want=1", ft_siwu); end
    n_vec++; if (ft_data_oe !== 1'b0)  begin n_err++; $display("FAIL reset_oe got=%b want=0", ft_data_oe); end
    n_vec++; if (ft_data_out !== 8'h00) begin n_err++; $display("FAIL reset_data got=%02h want=00", ft_data_out); end
    n_vec++; if (bus_req !== 1'b0)     begin n_err++; $display("FAIL reset_req got=%b want=0", bus_req); end
    n_vec++; if (tx_count !== 16'h0)   begin n_err++; $display("FAIL reset_count got=%0d want=0", tx_count); end
    n_vec++; if (tx_if.tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b want=1", tx_if.tx_ready); end
    n_vec++; if (dbg_state !== IDLE)   begin n_err++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] b [3];
    bit ok, all_ok;
    b = '{8'h11, 8'h22, 8'h33};
    bus_gnt = 1'b1;
    ft_txen = 1'b0;
    all_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_byte(b[i], ok);
      all_ok &= ok;
    end
    n_vec++; if (!all_ok) begin n_err++; $display("FAIL basic_push timeout got=0 want=1"); end
    // Two edges after the first push: turnaround cycle with the head on the bus.
    @(negedge ft_clk);
    n_vec++; if (dbg_state !== TURN || ft_data_oe !== 1'b1 || ft_wrn !== 1'b1 || ft_data_out !== 8'h11) begin
      n_err++; $display("FAIL basic_turn got=st%0d oe%b wrn%b d%02h want=st%0d oe1 wrn1 d11", dbg_state, ft_data_oe, ft_wrn, ft_data_out, TURN);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge ft_clk);
      n_vec++; if (ft_wrn !== 1'b0 || ft_data_out !== b[i]) begin
        n_err++; $display("FAIL basic_write%0d got=wrn%b d%02h want=wrn0 d%02h", i, ft_wrn, ft_data_out, b[i]);
      end
      tick();
    end
    @(negedge ft_clk);
    n_vec++; if (ft_wrn !== 1'b1 || ft_data_oe !== 1'b1 || dbg_state !== RELEASE) begin
      n_err++; $display("FAIL basic_release got=wrn%b oe%b st%0d want=wrn1 oe1 st%0d", ft_wrn, ft_data_oe, dbg_state, RELEASE);
    end
    n_vec++; if (tx_count !== 16'd3) begin n_err++; $display("FAIL basic_count got=%0d want=3", tx_count); end
    tick();
    @(negedge ft_clk);
    n_vec++; if (ft_data_oe !== 1'b0 || bus_req !== 1'b0 || dbg_state !== IDLE) begin
      n_err++; $display("FAIL basic_idle got=oe%b req%b st%0d want=oe0 req0 st%0d", ft_data_oe, bus_req, dbg_state, IDLE);
    end
    tick();
  endtask

  task automatic test_txen_stall();
    logic [15:0] base;
    bit ok, all_ok;
    base = exp_cnt;
    all_ok = 1'b1;
    push_byte(8'h11, ok); all_ok &= ok;
    push_byte(8'h22, ok); all_ok &= ok;
    push_byte(8'h33, ok); all_ok &= ok;
    tick();  // TURN -> WRITE, 0x11 on bus
    tick();  // 0x11 accepted, 0x22 loaded
    ft_txen = 1'b1;
    @(negedge ft_clk);
    n_vec++; if (ft_wrn !== 1'b0 || ft_data_out !== 8'h22) begin
      n_err++; $display("FAIL stall_present got=wrn%b d%02h want=wrn0 d22", ft_wrn, ft_data_out);
    end
    tick();  // refused: 0x22 held, bus released
    @(negedge ft_clk);
    n_vec++; if (ft_wrn !== 1'b1 || ft_data_out !== 8'h22 || tx_count !== base + 16'd1) begin
      n_err++; $display("FAIL stall_hold got=wrn%b d%02h cnt%0d want=wrn1 d22 cnt%0d", ft_wrn, ft_data_out, tx_count, base + 16'd1);
    end
    tick();
    ft_txen = 1'b0;
    @(negedge ft_clk);
    n_vec++; if (tx_count !== base + 16'd1 || ft_data_oe !== 1'b0) begin
      n_err++; $display("FAIL stall_idle got=cnt%0d oe%b want=cnt%0d oe0", tx_count, ft_data_oe, base + 16'd1);
    end
    wait_drained(ok);
    all_ok &= ok;
    n_vec++; if (!all_ok) begin n_err++; $display("FAIL stall_drain timeout pending=%0d want=0", exp_q.size()); end
    n_vec++; if (tx_count !== base + 16'd3) begin n_err++; $display("FAIL stall_count got=%0d want=%0d", tx_count, base + 16'd3); end
  endtask

  task automatic test_siwu();
    bit ok;
    int lows = 0;
    int first = -1;
    push_byte(8'h5A, ok);
    wait_drained(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL siwu_drain timeout pending=%0d want=0", exp_q.size()); end
    for (int i = 0; i < 150; i++) begin
      @(negedge ft_clk);
      if (ft_siwu === 1'b0) begin
        lows++;
        if (first < 0) first = cyc - last_acc_cyc;
      end
    end
    tick();
    // Pulse appears on the 33rd edge after the accepting edge (32 quiet cycles first).
    n_vec++; if (lows !== 1) begin n_err++; $display("FAIL siwu_pulses got=%0d want=1", lows); end
    n_vec++; if (first !== 34) begin n_err++; $display("FAIL siwu_delay got=%0d want=34", first); end
  endtask

  task automatic test_burst();
    logic [15:0] base;
    bit ok, all_ok;
    base = exp_cnt;
    ten_q.delete();
    ten_acc = 0;
    all_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      push_byte(8'(i * 3 + 7), ok);
      all_ok &= ok;
    end
    wait_drained(ok);
    all_ok &= ok;
    n_vec++; if (!all_ok) begin n_err++; $display("FAIL burst_drain timeout pending=%0d want=0", exp_q.size()); end
    n_vec++; if (ten_q.size() !== 2) begin
      n_err++; $display("FAIL burst_tenures got=%0d want=2", ten_q.size());
    end else begin
      n_vec++; if (ten_q[0] !== 64) begin n_err++; $display("FAIL burst_first got=%0d want=64", ten_q[0]); end
      n_vec++; if (ten_q[1] !== 36) begin n_err++; $display("FAIL burst_second got=%0d want=36", ten_q[1]); end
    end
    n_vec++; if (tx_count !== base + 16'd100) begin n_err++; $display("FAIL burst_count got=%0d want=%0d", tx_count, base + 16'd100); end
  endtask

  task automatic test_yield();
    logic [15:0] base;
    bit ok, all_ok;
    base = exp_cnt;
    bus_gnt = 1'b0;
    all_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_byte(8'hA0 + 8'(i), ok);
      all_ok &= ok;
    end
    @(negedge ft_clk);
    n_vec++; if (dbg_state !== REQ || bus_req !== 1'b1 || ft_wrn !== 1'b1) begin
      n_err++; $display("FAIL yield_req got=st%0d req%b wrn%b want=st%0d req1 wrn1", dbg_state, bus_req, ft_wrn, REQ);
    end
    tick();
    bus_gnt = 1'b1;
    repeat (5) tick();  // TURN, WRITE, then bytes 0..2 accepted
    bus_yield = 1'b1;
    @(negedge ft_clk);
    n_vec++; if (ft_wrn !== 1'b0) begin n_err++; $display("FAIL yield_busy got=wrn%b want=wrn0", ft_wrn); end
    tick();
    bus_yield = 1'b0;
    @(negedge ft_clk);
    n_vec++; if (ft_wrn !== 1'b1 || ft_data_oe !== 1'b1 || tx_count !== base + 16'd4) begin
      n_err++; $display("FAIL yield_release got=wrn%b oe%b cnt%0d want=wrn1 oe1 cnt%0d", ft_wrn, ft_data_oe, tx_count, base + 16'd4);
    end
    tick();
    @(negedge ft_clk);
    n_vec++; if (ft_data_oe !== 1'b0 || bus_req !== 1'b0) begin
      n_err++; $display("FAIL yield_drop got=oe%b req%b want=oe0 req0", ft_data_oe, bus_req);
    end
    wait_drained(ok);
    all_ok &= ok;
    n_vec++; if (!all_ok) begin n_err++; $display("FAIL yield_drain timeout pending=%0d want=0", exp_q.size()); end
    n_vec++; if (tx_count !== base + 16'd10) begin n_err++; $display("FAIL yield_count got=%0d want=%0d", tx_count, base + 16'd10); end
  endtask

  task automatic test_reset_mid();
    bit ok, all_ok;
    int lows = 0;
    all_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_byte(8'hC0 + 8'(i), ok);
      all_ok &= ok;
    end
    @(negedge ft_clk);
    n_vec++; if (!all_ok || dbg_state !== WRITE) begin
      n_err++; $display("FAIL rmid_write got=st%0d ok%b want=st%0d ok1", dbg_state, all_ok, WRITE);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (ft_wrn !== 1'b1 || ft_data_oe !== 1'b0 || bus_req !== 1'b0) begin
      n_err++; $display("FAIL rmid_async got=wrn%b oe%b req%b want=wrn1 oe0 req0", ft_wrn, ft_data_oe, bus_req);
    end
    n_vec++; if (tx_count !== 16'h0 || tx_if.tx_ready !== 1'b1 || dbg_state !== IDLE) begin
      n_err++; $display("FAIL rmid_state got=cnt%0d rdy%b st%0d want=cnt0 rdy1 st%0d", tx_count, tx_if.tx_ready, dbg_state, IDLE);
    end
    exp_q.delete();
    exp_cnt = '0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge ft_clk);
      if (ft_wrn === 1'b0 || bus_req === 1'b1) lows++;
    end
    n_vec++; if (lows !== 0) begin n_err++; $display("FAIL rmid_dropped got=%0d bus cycles want=0", lows); end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    test_reset();
    test_basic();
    test_txen_stall();
    test_siwu();
    test_burst();
    test_yield();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog expired got=running want=finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
